ifetch_queue: RTL and testbench

- Fetch-side buffer directly downstream of the PC register.
- Captures each {PC, instruction} pair produced by the PC register and instruction memory, and presents them in order to decode.
- Valid/ready handshake on both sides lets decode stall without losing fetched words.
- Synchronous flush discards everything in flight on a branch or jump redirect.

---
 rtl/ifetch_queue.sv | 107 ++++++++++
 tb/tb_ifetch_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: in-order buffer between the PC register / instruction memory
// and decode. Each entry holds one {PC, instruction} pair. The queue uses a
// valid/ready handshake on both sides so decode can stall without losing
// fetched words. A synchronous flush empties the queue on a redirect.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = reset asserted)
//   in_valid   upstream presents a fetched pair
//   in_ready   queue can accept a pair (count != DEPTH)
//   in_pc      PC of the fetched instruction
//   in_instr   fetched instruction word
//   out_valid  head entry is valid for decode (count != 0)
//   out_ready  decode consumes the head entry
//   out_pc     PC of the head entry
//   out_instr  instruction of the head entry
//   flush      discard all entries; has priority over push and pop
//   count      current occupancy, 0..DEPTH
//
// All status and data outputs are decoded from registers only. There is no
// empty-queue bypass, so the minimum latency from push to out_valid is one
// cycle. A full queue does not accept a push even when a pop happens in the
// same cycle.
module ifetch_queue #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_instr,
    input  logic             flush,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    logic [WIDTH-1:0] mem_pc    [DEPTH];
    logic [WIDTH-1:0] mem_instr [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;

    logic do_push;
    logic do_pop;

    // Ready/valid come only from the occupancy register.
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign out_pc    = mem_pc[rd_ptr];
    assign out_instr = mem_instr[rd_ptr];

    assign do_push = in_valid  && in_ready  && !flush;
    assign do_pop  = out_valid && out_ready && !flush;

    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
    // from DEPTH-1 to 0 through natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + ONE_COUNT;
                2'b01:   count_q <= count_q - ONE_COUNT;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is cleared on reset so out_pc/out_instr read as zero; a flush
    // leaves contents in place because out_valid already masks them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else if (do_push) begin
            mem_pc[wr_ptr]    <= in_pc;
            mem_instr[wr_ptr] <= in_instr;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        flush;
    logic [2:0]  count;

    ifetch_queue #(.WIDTH(32), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ordy;
        logic        fl;
        logic [2:0]  exp_count;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } pair_t;

    localparam int NVEC = 18;
    localparam logic [31:0] XK = 32'hA5A5_A5A5;

    vec_t  vecs [NVEC];
    pair_t sb   [$];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs are driven now (just after a rising edge),
    // outputs are checked against the scoreboard at the falling edge, the
    // model advances, and occupancy is checked just after the next rising edge.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                        input logic ordy, input logic fl, input int exp_count);
        pair_t p;
        logic  m_push;
        logic  m_pop;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        chk("in_ready",  32'(in_ready),  32'(sb.size() != 4));
        if (sb.size() != 0) begin
            chk("head_pc",    out_pc,    sb[0].pc);
            chk("head_instr", out_instr, sb[0].instr);
        end
        m_push = iv && (sb.size() != 4) && !fl;
        m_pop  = (sb.size() != 0) && ordy && !fl;
        if (fl) begin
            sb.delete();
        end else begin
            if (m_pop) void'(sb.pop_front());
            if (m_push) begin
                p.pc = pc;
                p.instr = instr;
                sb.push_back(p);
            end
        end
        @(posedge clk);
        #1;
        chk("count_model", 32'(count), 32'(sb.size()));
        if (exp_count >= 0) chk("count_table", 32'(count), 32'(exp_count));
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic ordy,
                                input logic fl, input logic [2:0] ec);
        vec_t v;
        v.iv = iv;
        v.pc = pc;
        v.instr = pc ^ XK;
        v.ordy = ordy;
        v.fl = fl;
        v.exp_count = ec;
        return v;
    endfunction

    initial begin
        // Single pass-through
        vecs[0]  = mk(1, 32'h0, 1, 0, 1);
        vecs[0].instr = 32'h0050_0093;
        vecs[1]  = mk(0, 32'h0, 1, 0, 0);
        // Fill and backpressure, then drain in order
        vecs[2]  = mk(1, 32'h0,  0, 0, 1);
        vecs[3]  = mk(1, 32'h4,  0, 0, 2);
        vecs[4]  = mk(1, 32'h8,  0, 0, 3);
        vecs[5]  = mk(1, 32'hC,  0, 0, 4);
        vecs[6]  = mk(1, 32'h10, 0, 0, 4);
        vecs[7]  = mk(0, 32'h0,  0, 0, 4);
        vecs[8]  = mk(1, 32'h10, 1, 0, 3);
        vecs[9]  = mk(0, 32'h0,  1, 0, 2);
        vecs[10] = mk(0, 32'h0,  1, 0, 1);
        vecs[11] = mk(0, 32'h0,  1, 0, 0);
        // Flush with a concurrent push and pop
        vecs[12] = mk(1, 32'h20,  0, 0, 1);
        vecs[13] = mk(1, 32'h24,  0, 0, 2);
        vecs[14] = mk(1, 32'h28,  0, 0, 3);
        vecs[15] = mk(1, 32'h100, 1, 1, 0);
        vecs[16] = mk(1, 32'h200, 0, 0, 1);
        vecs[17] = mk(0, 32'h0,   1, 0, 0);

        reset = 1'b0;
        in_valid = 1'b1;
        in_pc = 32'h1234_5678;
        in_instr = 32'h9ABC_DEF0;
        out_ready = 1'b0;
        flush = 1'b0;

        // Reset held for two cycles with in_valid asserted
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_pc",    out_pc,         32'd0);
        chk("rst_out_instr", out_instr,      32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(0, 32'h0, 32'h0, 1, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].ordy, vecs[i].fl,
                 int'(vecs[i].exp_count));
        end

        // Streaming across the pointer wrap: count holds at 1
        for (int i = 0; i < 10; i++) begin
            step(1, 32'(i * 4), 32'(i * 4) ^ XK, 1, 0, 1);
        end
        step(0, 32'h0, 32'h0, 1, 0, 0);

        // Async reset mid-stream with two entries queued
        step(1, 32'h300, 32'h300 ^ XK, 0, 0, 1);
        step(1, 32'h304, 32'h304 ^ XK, 0, 0, 2);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_count",     32'(count),     32'd0);
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready",  32'(in_ready),  32'd1);
        chk("async_out_pc",    out_pc,         32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(1, 32'h400, 32'h400 ^ XK, 0, 0, 1);
        step(0, 32'h0, 32'h0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
